control_teclado_eventos: RTL and testbench
==========================================

Name: control_teclado_eventos

Overview:
Keyboard event controller between the four raw push-buttons and the processor I/O port. It synchronises and debounces each button, detects presses, and arbitrates simultaneous presses with a fixed priority. Press codes are queued in a small FIFO, exposed through data and status read ports, and an interrupt is raised when a new event is queued. A control write port configures the block.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (bench uses 8)
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
PORT_DATA, 8'h03, Port_ID for the FIFO head read
PORT_STATUS, 8'h04, Port_ID for the status read
PORT_CTRL, 8'h05, Port_ID for the control write

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
aumenta  in  1  raw button, active-high
disminuye  in  1  raw button, active-high
siguiente  in  1  raw button, active-high
anterior  in  1  raw button, active-high
Port_ID  in  8  processor port address
read_strobe  in  1  processor read strobe
write_strobe  in  1  processor write strobe
Out_Port  in  8  processor write data
In_Port  out  8  registered read data
interrupt  out  1  processor interrupt request
interrupt_ack  in  1  processor interrupt acknowledge

Behaviour:
- Reset (reset=0, asynchronous): In_Port=0, interrupt=0, FIFO empty, pending=0, overflow=0, debounced levels=0, counters=0, int_en=1.
- Synchronisation: each button passes through a 2-FF synchroniser.
- Debounce, per button:
  - Counter increments while the synchronised input differs from the debounced level.
  - Counter clears as soon as the input matches the debounced level again.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the input value and the counter clears.
- Press detection: a 0->1 transition of the debounced level produces a 1-cycle press pulse. Releases generate nothing.
- Pending flags: a press pulse sets that button's pending bit. If the bit is already set, the press is merged and the overflow flag is set (sticky).
- Arbitration: at most one enqueue per cycle. The highest-priority pending bit is enqueued, then cleared. Priority: aumenta > disminuye > siguiente > anterior.
- Codes: aumenta=8'h04, disminuye=8'h05, siguiente=8'h06, anterior=8'h07.
- FIFO: depth 4, 3-bit count, read/write pointers wrap mod 4.
  - Enqueue is blocked when full; pending bits are held, not dropped.
  - Enqueue is allowed when full if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- Read mux, 1-cycle latency: every clk, In_Port is loaded from the current Port_ID.
  - PORT_DATA -> FIFO head, or 8'h00 if empty.
  - PORT_STATUS -> {overflow, full, 3'b000, count[2:0]}.
  - Any other Port_ID -> 8'h00.
- Pop: read_strobe=1 with Port_ID=PORT_DATA and FIFO non-empty pops the head at that edge. In_Port already holds that head value. Reading an empty FIFO pops nothing.
- Control write: write_strobe=1 with Port_ID=PORT_CTRL, using Out_Port bits:
  - bit0=1: flush FIFO and pending bits. A flush beats a same-cycle enqueue.
  - bit1=1: clear overflow. A same-cycle merge wins and leaves overflow set.
  - bit2: loaded into int_en.
  - Other bits are ignored.
- Interrupt:
  - Set on the cycle after any enqueue while int_en=1.
  - Cleared on interrupt_ack=1; ack beats a same-cycle set.
  - Writing int_en=0 clears interrupt immediately.
  - The interrupt is not re-armed by residual FIFO contents.
- Latency, single press, FIFO not full: the code is at the FIFO head DEBOUNCE_CYCLES+4 cycles after the raw rising edge.
- Reset mid-operation: everything returns immediately to the reset values. Partially counted bounces are discarded.

Test Plan:
- Reset, then read PORT_STATUS -> In_Port=8'h00. Read PORT_DATA -> 8'h00, no pop, count stays 0.
- aumenta held for 20 cycles (DEBOUNCE_CYCLES=8) -> 12 cycles after the edge, status=8'h01 and interrupt=1. Read PORT_DATA -> 8'h04, then status=8'h00. interrupt_ack -> interrupt=0.
- aumenta toggled every 3 cycles for 30 cycles, then released -> no enqueue, count 0, interrupt stays 0.
- All four buttons pressed in the same cycle -> enqueued on 4 consecutive cycles. Four PORT_DATA reads return 04, 05, 06, 07. Status reads 8'h44 after the 4th enqueue.
- FIFO full (4 entries), then siguiente pressed twice -> status=8'hC4 (overflow=1, full=1); one pop -> siguiente (06) enqueues.
- Write PORT_CTRL=8'h03 with a full FIFO -> status=8'h00, pending cleared. Write 8'h00, then a press -> enqueued, interrupt stays 0.

Source files
------------

// File: rtl/control_teclado_eventos.sv
// Keyboard event controller: synchronises and debounces four push-buttons, queues
// press codes in a 4-entry FIFO and exposes them through the processor I/O port.
module control_teclado_eventos #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         CNT_W           = 19,
   parameter logic [7:0] PORT_DATA       = 8'h03,
   parameter logic [7:0] PORT_STATUS     = 8'h04,
   parameter logic [7:0] PORT_CTRL       = 8'h05
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       aumenta,
   input  logic       disminuye,
   input  logic       siguiente,
   input  logic       anterior,
   input  logic [7:0] Port_ID,
   input  logic       read_strobe,
   input  logic       write_strobe,
   input  logic [7:0] Out_Port,
   output logic [7:0] In_Port,
   output logic       interrupt,
   input  logic       interrupt_ack
);

   typedef logic [CNT_W-1:0] cnt_t;

   // Index 0 is the highest-priority button.
   logic [3:0] btn_raw;
   logic [3:0] sync1, sync2, level;
   logic [3:0] accept, press;
   cnt_t       cnt [4];

   assign btn_raw = {anterior, siguiente, disminuye, aumenta};

   // A press is flagged in the cycle the debounced level is about to rise, so the
   // pending bit is set on the same edge that updates the level.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         accept[i] = (sync2[i] != level[i]) && (cnt[i] == cnt_t'(DEBOUNCE_CYCLES - 1));
         press[i]  = accept[i] && sync2[i];
      end
   end

   // NOTE: every register here is updated with <=, so all reads see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               cnt[i]   <= '0;
               level[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + cnt_t'(1);
            end
         end
      end
   end

   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic [3:0] pending, grant;
   logic [7:0] push_code, rd_mux;
   logic       full, empty, pop, push, ctrl_wr, flush, merge;
   logic       int_en, overflow;
   logic       ctrl_unused;

   assign full        = (count == 3'd4);
   assign empty       = (count == 3'd0);
   assign pop         = read_strobe && (Port_ID == PORT_DATA) && !empty;
   assign ctrl_wr     = write_strobe && (Port_ID == PORT_CTRL);
   assign flush       = ctrl_wr && Out_Port[0];
   assign merge       = |(press & pending);
   assign push        = (|pending) && !flush && (!full || pop);
   assign ctrl_unused = ^Out_Port[7:3];

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      grant     = 4'b0000;
      push_code = 8'h00;
      if (pending[0]) begin
         grant     = 4'b0001;
         push_code = 8'h04;
      end else if (pending[1]) begin
         grant     = 4'b0010;
         push_code = 8'h05;
      end else if (pending[2]) begin
         grant     = 4'b0100;
         push_code = 8'h06;
      end else if (pending[3]) begin
         grant     = 4'b1000;
         push_code = 8'h07;
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      if (Port_ID == PORT_DATA) begin
         rd_mux = empty ? 8'h00 : mem[rd_ptr];
      end else if (Port_ID == PORT_STATUS) begin
         rd_mux = {overflow, full, 3'b000, count};
      end
   end

   // NOTE: the FIFO storage has no reset; an empty FIFO never exposes its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_code;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pending   <= '0;
         overflow  <= 1'b0;
         int_en    <= 1'b1;
         interrupt <= 1'b0;
         In_Port   <= 8'h00;
      end else begin
         In_Port <= rd_mux;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
               2'b10:   count <= count + 3'd1;
               2'b01:   count <= count - 3'd1;
               default: count <= count;
            endcase
         end

         // A press landing on an already-pending button is merged into that event.
         if (flush) pending <= '0;
         else       pending <= (pending | press) & ~(push ? grant : 4'b0000);

         if (merge)                       overflow <= 1'b1;
         else if (ctrl_wr && Out_Port[1]) overflow <= 1'b0;

         if (ctrl_wr) int_en <= Out_Port[2];

         if (interrupt_ack || (ctrl_wr && !Out_Port[2])) interrupt <= 1'b0;
         else if (push && int_en)                        interrupt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_control_teclado_eventos.sv
// Randomised bench for control_teclado_eventos against an event-level reference model,
// preceded by a short directed walk through the main use cases.
module tb_control_teclado_eventos;

   localparam int         D      = 8;
   localparam logic [7:0] P_DATA = 8'h03;
   localparam logic [7:0] P_STAT = 8'h04;
   localparam logic [7:0] P_CTRL = 8'h05;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       rd = 1'b0, wr = 1'b0, ack = 1'b0;
   logic [7:0] in_port;
   logic       irq;

   always #5 clk = ~clk;

   control_teclado_eventos #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(4),
      .PORT_DATA(P_DATA),
      .PORT_STATUS(P_STAT),
      .PORT_CTRL(P_CTRL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .aumenta(btn[0]),
      .disminuye(btn[1]),
      .siguiente(btn[2]),
      .anterior(btn[3]),
      .Port_ID(port_id),
      .read_strobe(rd),
      .write_strobe(wr),
      .Out_Port(out_port),
      .In_Port(in_port),
      .interrupt(irq),
      .interrupt_ack(ack)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a button registers a press once its synchronised value has
   // disagreed with the accepted level for D samples in a row.
   bit         m_d1 [4];
   bit         m_d2 [4];
   bit         m_lvl [4];
   logic [D-1:0] m_win [4];
   int         m_fill [4];
   bit         m_pend [4];
   bit         m_ovf, m_int_en, m_irq;
   logic [7:0] m_in;
   logic [7:0] m_fifo [$];

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0;
         m_win[b] = '0; m_fill[b] = 0; m_pend[b] = 0;
      end
      m_ovf = 0; m_int_en = 1; m_irq = 0; m_in = 8'h00;
      m_fifo.delete();
   endtask

   task automatic model_step();
      logic [7:0] nxt;
      int  sz, g;
      bit  s, pop_ev, ctrl, flush, merge;
      bit  press [4];
      sz = m_fifo.size();
      if (port_id == P_DATA)      nxt = (sz > 0) ? m_fifo[0] : 8'h00;
      else if (port_id == P_STAT) nxt = {m_ovf, sz == 4, 3'b000, 3'(sz)};
      else                        nxt = 8'h00;
      pop_ev = rd && (port_id == P_DATA) && (sz > 0);
      ctrl   = wr && (port_id == P_CTRL);
      flush  = ctrl && out_port[0];
      g = -1;
      if (!flush && (sz < 4 || pop_ev))
         for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
      merge = 0;
      for (int b = 0; b < 4; b++) begin
         s = m_d2[b]; m_d2[b] = m_d1[b]; m_d1[b] = btn[b];
         m_win[b] = {m_win[b][D-2:0], s};
         if (m_fill[b] < D) m_fill[b]++;
         press[b] = 0;
         if (m_fill[b] == D && m_win[b] == {D{~m_lvl[b]}}) begin
            m_lvl[b] = ~m_lvl[b];
            m_fill[b] = 0;
            press[b] = m_lvl[b];
         end
         if (press[b] && m_pend[b]) merge = 1;
      end
      if (ctrl && out_port[1]) m_ovf = 0;
      if (merge) m_ovf = 1;
      for (int b = 0; b < 4; b++) if (press[b]) m_pend[b] = 1;
      if (g >= 0) m_pend[g] = 0;
      if (flush) for (int b = 0; b < 4; b++) m_pend[b] = 0;
      if (flush) m_fifo.delete();
      else begin
         if (pop_ev) void'(m_fifo.pop_front());
         if (g >= 0) m_fifo.push_back(8'h04 + 8'(g));
      end
      if (ack || (ctrl && !out_port[2])) m_irq = 0;
      else if (g >= 0 && m_int_en)       m_irq = 1;
      if (ctrl) m_int_en = out_port[2];
      m_in = nxt;
   endtask

   task automatic cycle();
      if (reset) model_step();
      else       model_reset();
      @(posedge clk); #1;
      check("in_port", in_port, m_in);
      check("interrupt", {7'b0, irq}, {7'b0, m_irq});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic ctrl_write(input logic [7:0] v);
      port_id = P_CTRL; out_port = v; wr = 1'b1;
      cycle();
      wr = 1'b0; out_port = 8'h00;
   endtask

   initial begin
      model_reset();
      run(2);
      reset = 1'b1;

      // Empty reads
      port_id = P_STAT; cycle(); check("rst_status", in_port, 8'h00);
      port_id = P_DATA; rd = 1'b1; cycle(); check("empty_read", in_port, 8'h00);
      rd = 1'b0; port_id = P_STAT; cycle(); check("empty_count", in_port, 8'h00);

      // Single press latency, pop and acknowledge
      btn[0] = 1'b1;
      run(11); check("lat_early", in_port, 8'h00);
      run(1);  check("lat_status", in_port, 8'h01); check("lat_irq", {7'b0, irq}, 8'h01);
      run(8);
      btn[0] = 1'b0;
      port_id = P_DATA; rd = 1'b1; cycle(); check("pop_data", in_port, 8'h04);
      rd = 1'b0; port_id = P_STAT; cycle(); check("after_pop", in_port, 8'h00);
      ack = 1'b1; cycle(); check("ack_irq", {7'b0, irq}, 8'h00);
      ack = 1'b0; run(12);

      // Bouncing input never qualifies
      for (int i = 0; i < 10; i++) begin
         btn[0] = ~btn[0];
         run(3);
      end
      btn[0] = 1'b0; run(12);
      check("bounce_status", in_port, 8'h00); check("bounce_irq", {7'b0, irq}, 8'h00);

      // Simultaneous presses drain in priority order
      btn = 4'b1111; run(14); check("three_status", in_port, 8'h03);
      run(1); check("four_status", in_port, 8'h44);
      btn = 4'b0000; run(12);
      port_id = P_DATA; rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("four_rd", in_port, 8'h04 + 8'(i));
      end
      rd = 1'b0; port_id = P_STAT; cycle(); check("drained", in_port, 8'h00);

      // Full FIFO, blocked and merged press, then refill on pop
      btn = 4'b1111; run(15); check("refill_status", in_port, 8'h44);
      btn = 4'b0000; run(12);
      btn[2] = 1'b1; run(12); btn[2] = 1'b0; run(12);
      btn[2] = 1'b1; run(12); btn[2] = 1'b0; run(12);
      check("ovf_status", in_port, 8'hC4);
      port_id = P_DATA; rd = 1'b1; cycle(); check("full_pop", in_port, 8'h04);
      rd = 1'b0; port_id = P_STAT; cycle(); check("pop_push_status", in_port, 8'hC4);

      // Flush, then interrupts disabled
      ctrl_write(8'h03);
      port_id = P_STAT; cycle();
      check("flush_status", in_port, 8'h00); check("flush_irq", {7'b0, irq}, 8'h00);
      ctrl_write(8'h00);
      port_id = P_STAT;
      btn[1] = 1'b1; run(12);
      check("noirq_status", in_port, 8'h01); check("noirq_irq", {7'b0, irq}, 8'h00);
      btn[1] = 1'b0; run(12);
      ctrl_write(8'h04);

      // Randomised traffic with alternating slow and fast draining
      for (int i = 0; i < 6000; i++) begin
         bit fast;
         int r;
         fast = ((i / 500) % 2) == 1;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
         r = $urandom_range(0, 9);
         if (r < 4)      port_id = P_DATA;
         else if (r < 7) port_id = P_STAT;
         else if (r < 8) port_id = P_CTRL;
         else            port_id = 8'($urandom);
         rd = fast ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         wr = (port_id == P_CTRL) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
         out_port = 8'($urandom);
         if ($urandom_range(0, 3) != 0) out_port[2] = 1'b1;
         ack = ($urandom_range(0, 7) == 0);
         if (i % 1500 == 777) begin
            reset = 1'b0;
            #1;
            check("async_rst_data", in_port, 8'h00);
            check("async_rst_irq", {7'b0, irq}, 8'h00);
            run(2);
            reset = 1'b1;
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
